// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the calculator operation sequencer: state encoding,
// strobe-vector bit positions and default datapath geometry.
package calc_op_sequencer_pkg;

    localparam int unsigned DefWidth = 5;
    localparam int unsigned DefDepth = 16;

    typedef enum logic [3:0] {
        StIdle,
        StAddrA,
        StRdA,
        StLdA,
        StAddrB,
        StRdB,
        StLdB,
        StExec,
        StAddrC,
        StWrC,
        StDone
    } state_e;

    localparam int unsigned StbMemAddrCen = 0;
    localparam int unsigned StbOpACen     = 1;
    localparam int unsigned StbOpBCen     = 2;
    localparam int unsigned StbResultCen  = 3;
    localparam int unsigned StbMemRead    = 4;
    localparam int unsigned StbMemWrite   = 5;
    localparam int unsigned StbWriteSel   = 6;
    localparam int unsigned NumStb        = 7;

    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Command and datapath-strobe bundle of the operation sequencer.
interface calc_op_sequencer_if import calc_op_sequencer_pkg::*; #(
    parameter int unsigned Width = DefWidth
) ();

    logic             start;
    logic             abort;
    logic [Width-1:0] addr_a;
    logic [Width-1:0] addr_b;
    logic [Width-1:0] addr_c;
    logic             ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [Width-1:0] keypad_value;
    logic             mem_addr_cen;
    logic             op_a_cen;
    logic             op_b_cen;
    logic             result_cen;
    logic             mem_read;
    logic             mem_write;
    logic             write_sel;
    logic             displ_sel;

    modport master (
        output start, abort, addr_a, addr_b, addr_c,
        input  ready, busy, done, err, keypad_value, mem_addr_cen, op_a_cen, op_b_cen,
        input  result_cen, mem_read, mem_write, write_sel, displ_sel
    );

    modport slave (
        input  start, abort, addr_a, addr_b, addr_c,
        output ready, busy, done, err, keypad_value, mem_addr_cen, op_a_cen, op_b_cen,
        output result_cen, mem_read, mem_write, write_sel, displ_sel
    );

endinterface

// File: rtl/calc_rd_wait.sv
// Loadable down-counter timing the memory read latency; expired_o marks the last wait cycle.
module calc_rd_wait #(
    parameter int unsigned Latency = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= 4'(Latency);
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign expired_o = (cnt_q == 4'd1);

endmodule

// File: rtl/calc_op_sequencer.sv
// Runs mem[addr_c] = mem[addr_a] op mem[addr_b] by driving the datapath strobes.
// Optional CALC_SEQ_OPCNT_EN adds a saturating completed-operation counter.
module calc_op_sequencer import calc_op_sequencer_pkg::*; #(
    parameter int unsigned Width    = DefWidth,
    parameter int unsigned Depth    = DefDepth,
    parameter int unsigned MemRdLat = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    calc_op_sequencer_if.slave    seq_if
`ifdef CALC_SEQ_OPCNT_EN
    ,
    output logic [15:0]           op_count_o
`endif
);

    state_e            state_q;
    logic [NumStb-1:0] stb_q;
    logic [Width-1:0]  addr_b_q, addr_c_q, keypad_q;
    logic              ready_q, done_q, err_q, displ_sel_q;
    logic              rd_load, rd_en, rd_expired, req_ok;
`ifdef CALC_SEQ_OPCNT_EN
    logic [15:0]       op_count_q;
`endif

    assign rd_load = (state_q == StAddrA) || (state_q == StAddrB);
    assign rd_en   = (state_q == StRdA) || (state_q == StRdB);
    assign req_ok  = addr_legal(32'(seq_if.addr_a), Depth) &&
                     addr_legal(32'(seq_if.addr_b), Depth) &&
                     addr_legal(32'(seq_if.addr_c), Depth);

    calc_rd_wait #(
        .Latency (MemRdLat)
    ) u_rd_wait (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (rd_load),
        .en_i      (rd_en),
        .expired_o (rd_expired)
    );

    // Outputs are set for the state being entered, so every output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stb_q       <= '0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            displ_sel_q <= 1'b0;
            keypad_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
`ifdef CALC_SEQ_OPCNT_EN
            op_count_q  <= 16'd0;
`endif
        end else begin
            stb_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (seq_if.abort && (state_q != StIdle)) begin
                state_q <= StIdle;
                ready_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (seq_if.start && !seq_if.abort) begin
                            addr_b_q <= seq_if.addr_b;
                            addr_c_q <= seq_if.addr_c;
                            if (req_ok) begin
                                state_q               <= StAddrA;
                                ready_q               <= 1'b0;
                                displ_sel_q           <= 1'b0;
                                keypad_q              <= seq_if.addr_a;
                                stb_q[StbMemAddrCen]  <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    StAddrA: begin
                        state_q            <= StRdA;
                        stb_q[StbMemRead]  <= 1'b1;
                    end
                    StRdA: begin
                        stb_q[StbMemRead] <= 1'b1;
                        if (rd_expired) begin
                            state_q          <= StLdA;
                            stb_q[StbOpACen] <= 1'b1;
                        end
                    end
                    StLdA: begin
                        state_q              <= StAddrB;
                        keypad_q             <= addr_b_q;
                        stb_q[StbMemAddrCen] <= 1'b1;
                    end
                    StAddrB: begin
                        state_q           <= StRdB;
                        stb_q[StbMemRead] <= 1'b1;
                    end
                    StRdB: begin
                        stb_q[StbMemRead] <= 1'b1;
                        if (rd_expired) begin
                            state_q          <= StLdB;
                            stb_q[StbOpBCen] <= 1'b1;
                        end
                    end
                    StLdB: begin
                        state_q             <= StExec;
                        stb_q[StbResultCen] <= 1'b1;
                    end
                    StExec: begin
                        state_q              <= StAddrC;
                        keypad_q             <= addr_c_q;
                        stb_q[StbMemAddrCen] <= 1'b1;
                    end
                    StAddrC: begin
                        state_q            <= StWrC;
                        stb_q[StbMemWrite] <= 1'b1;
                        stb_q[StbWriteSel] <= 1'b1;
                    end
                    StWrC: begin
                        state_q     <= StDone;
                        done_q      <= 1'b1;
                        displ_sel_q <= 1'b1;
`ifdef CALC_SEQ_OPCNT_EN
                        if (op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
`endif
                    end
                    StDone: begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign seq_if.ready        = ready_q;
    assign seq_if.busy         = ~ready_q;
    assign seq_if.done         = done_q;
    assign seq_if.err          = err_q;
    assign seq_if.keypad_value = keypad_q;
    assign seq_if.mem_addr_cen = stb_q[StbMemAddrCen];
    assign seq_if.op_a_cen     = stb_q[StbOpACen];
    assign seq_if.op_b_cen     = stb_q[StbOpBCen];
    assign seq_if.result_cen   = stb_q[StbResultCen];
    assign seq_if.mem_read     = stb_q[StbMemRead];
    assign seq_if.mem_write    = stb_q[StbMemWrite];
    assign seq_if.write_sel    = stb_q[StbWriteSel];
    assign seq_if.displ_sel    = displ_sel_q;
`ifdef CALC_SEQ_OPCNT_EN
    assign op_count_o          = op_count_q;
`endif

endmodule
